// File: rtl/sirv_tl_frag_sequencer.sv
// -----------------------------------------------------------------------------
// sirv_tl_frag_sequencer
//
// Splits one multi-beat TileLink-UL A-channel request, presented by a
// single-beat repeater, into a train of beat-sized fragments for a narrow
// slave port. The block drives the repeater's repeat input. It generates the
// address and size of each fragment. It also counts in-flight fragments
// against D-channel acknowledgements, which limits how many are outstanding.
//
// Ports
//   clock, rst_n        rising-edge clock, asynchronous active-low reset
//   rep_valid/ready     repeater dequeue handshake
//   rep_repeat          ask the repeater to hold the current Get request
//   rep_opcode/param/size/source/address/mask/data   current A request
//   out_valid/ready     fragment handshake toward the slave
//   out_opcode/param/source/mask/data                passed through
//   out_size/address    per-fragment size and address
//   out_last            final fragment of the burst
//   d_fire              one D-channel acknowledgement accepted downstream
//   busy                burst in progress or fragments outstanding
//
// Optional feature (macro SIRV_FRAG_PERF_CNT_EN)
//   frag_count          16-bit wrapping count of issued fragments
//   frag_count_clr      synchronous clear; wins over a simultaneous fire
// -----------------------------------------------------------------------------
module sirv_tl_frag_sequencer #(
  parameter int ADDR_W  = 30,
  parameter int SRC_W   = 2,
  parameter int BEAT_LG = 2,
  parameter int MAX_LG  = 6,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              rep_valid,
  output logic              rep_ready,
  output logic              rep_repeat,
  input  logic [2:0]        rep_opcode,
  input  logic [2:0]        rep_param,
  input  logic [2:0]        rep_size,
  input  logic [SRC_W-1:0]  rep_source,
  input  logic [ADDR_W-1:0] rep_address,
  input  logic [3:0]        rep_mask,
  input  logic [31:0]       rep_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [2:0]        out_param,
  output logic [SRC_W-1:0]  out_source,
  output logic [3:0]        out_mask,
  output logic [31:0]       out_data,
  output logic [2:0]        out_size,
  output logic [ADDR_W-1:0] out_address,
  output logic              out_last,
  input  logic              d_fire,
`ifdef SIRV_FRAG_PERF_CNT_EN
  output logic [15:0]       frag_count,
  input  logic              frag_count_clr,
`endif
  output logic              busy
);

  localparam int BW = MAX_LG - BEAT_LG;

  logic [BW-1:0] beat_idx_q, beat_idx_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic [BW-1:0] last_idx;
  logic          stall;
  logic          fire;

  // Index of the final beat, equal to beats-1. Each bit is set when the
  // transfer is larger than the matching beat multiple.
  function automatic logic [BW-1:0] last_idx_f(input logic [2:0] sz);
    logic [BW-1:0] m;
    m = '0;
    for (int i = 0; i < BW; i++) begin
      if (int'(sz) > BEAT_LG + i) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Outstanding counter update. An acknowledgement that arrives while the
  // counter is empty is illegal; the counter holds at zero in that case.
  function automatic logic [3:0] out_cnt_f(input logic [3:0] cnt,
                                           input logic       inc,
                                           input logic       dec);
    logic [3:0] r;
    r = cnt;
    if (inc && !dec)                 r = cnt + 4'd1;
    else if (!inc && dec && cnt != 0) r = cnt - 4'd1;
    return r;
  endfunction

  assign out_opcode = rep_opcode;
  assign out_param  = rep_param;
  assign out_source = rep_source;
  assign out_mask   = rep_mask;
  assign out_data   = rep_data;

  always_comb begin
    last_idx    = last_idx_f(rep_size);
    out_last    = (beat_idx_q == last_idx);
    stall       = (outstanding_q == 4'(MAX_OUT));
    out_valid   = rep_valid & ~stall;
    rep_ready   = out_ready & ~stall;
    fire        = out_valid & out_ready;
    // Only a Get is replayed by the repeater. A Put delivers a new data beat
    // upstream for every fragment.
    rep_repeat  = ~out_last & (rep_opcode == 3'd4);
    out_size    = (rep_size < 3'(BEAT_LG)) ? rep_size : 3'(BEAT_LG);
    // The base address is size-aligned, so ORing in the beat index walks the
    // beats. beat_idx is zero for single-beat requests.
    out_address = rep_address;
    out_address[MAX_LG-1:BEAT_LG] = rep_address[MAX_LG-1:BEAT_LG] | beat_idx_q;
    beat_idx_d  = beat_idx_q;
    if (fire) beat_idx_d = out_last ? '0 : beat_idx_q + 1'b1;
    outstanding_d = out_cnt_f(outstanding_q, fire, d_fire);
    busy        = (beat_idx_q != '0) | (outstanding_q != 4'd0);
  end

  // state registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx_q    <= '0;
      outstanding_q <= 4'd0;
    end else begin
      beat_idx_q    <= beat_idx_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef SIRV_FRAG_PERF_CNT_EN
  logic [15:0] frag_count_q, frag_count_d;

  always_comb begin
    frag_count_d = frag_count_q;
    if (frag_count_clr) frag_count_d = 16'd0;
    else if (fire)      frag_count_d = frag_count_q + 16'd1;
  end

  // performance counter register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) frag_count_q <= 16'd0;
    else        frag_count_q <= frag_count_d;
  end

  assign frag_count = frag_count_q;
`endif

  a_size_legal: assert property (@(posedge clock) disable iff (!rst_n)
    rep_valid |-> (rep_size <= 3'(MAX_LG)));

endmodule

// File: tb/tb_sirv_tl_frag_sequencer.sv
module tb_sirv_tl_frag_sequencer;

  logic        clock;
  logic        rst_n;
  logic        rep_valid;
  logic        rep_ready;
  logic        rep_repeat;
  logic [2:0]  rep_opcode;
  logic [2:0]  rep_param;
  logic [2:0]  rep_size;
  logic [1:0]  rep_source;
  logic [29:0] rep_address;
  logic [3:0]  rep_mask;
  logic [31:0] rep_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [2:0]  out_param;
  logic [1:0]  out_source;
  logic [3:0]  out_mask;
  logic [31:0] out_data;
  logic [2:0]  out_size;
  logic [29:0] out_address;
  logic        out_last;
  logic        d_fire;
  logic        busy;
`ifdef SIRV_FRAG_PERF_CNT_EN
  logic [15:0] frag_count;
  logic        frag_count_clr;
`endif

  int n_chk;
  int n_err;

  sirv_tl_frag_sequencer dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .rep_valid   (rep_valid),
    .rep_ready   (rep_ready),
    .rep_repeat  (rep_repeat),
    .rep_opcode  (rep_opcode),
    .rep_param   (rep_param),
    .rep_size    (rep_size),
    .rep_source  (rep_source),
    .rep_address (rep_address),
    .rep_mask    (rep_mask),
    .rep_data    (rep_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_param   (out_param),
    .out_source  (out_source),
    .out_mask    (out_mask),
    .out_data    (out_data),
    .out_size    (out_size),
    .out_address (out_address),
    .out_last    (out_last),
    .d_fire      (d_fire),
`ifdef SIRV_FRAG_PERF_CNT_EN
    .frag_count     (frag_count),
    .frag_count_clr (frag_count_clr),
`endif
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs then change 1 time unit after the edge
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] sz,
                     input logic [29:0] a, input logic [31:0] dat);
    rep_valid   = 1'b1;
    rep_opcode  = op;
    rep_size    = sz;
    rep_address = a;
    rep_data    = dat;
  endtask

  // retire n acknowledgements with no request pending
  task automatic drain(input int n);
    rep_valid = 1'b0;
    d_fire    = 1'b1;
    repeat (n) cyc();
    d_fire    = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n       = 1'b0;
    rep_valid   = 1'b0;
    rep_opcode  = 3'd4;
    rep_param   = 3'd0;
    rep_size    = 3'd4;
    rep_source  = 2'd2;
    rep_address = 30'h100;
    rep_mask    = 4'hF;
    rep_data    = 32'h0;
    out_ready   = 1'b1;
    d_fire      = 1'b0;
`ifdef SIRV_FRAG_PERF_CNT_EN
    frag_count_clr = 1'b0;
`endif
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_repeat", 32'(rep_repeat), 1);
    cyc();
    cyc();
    rst_n = 1'b1;

    // 1: Get 16 bytes at 0x100 -> four beats
    for (int i = 0; i < 4; i++) begin
      req(3'd4, 3'd4, 30'h100, 32'h0);
      #1;
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_addr", 32'(out_address), 32'h100 + 32'(4 * i));
      chk("t1_size", 32'(out_size), 2);
      chk("t1_repeat", 32'(rep_repeat), 32'(i < 3));
      chk("t1_last", 32'(out_last), 32'(i == 3));
      chk("t1_source", 32'(out_source), 2);
      cyc();
      chk("t1_busy", 32'(busy), 1);
    end
    drain(4);
    chk("t1_idle", 32'(busy), 0);

    // 2: single-beat Get, plus a sub-beat one for the size clamp
    req(3'd4, 3'd2, 30'h20, 32'h0);
    #1;
    chk("t2_addr", 32'(out_address), 32'h20);
    chk("t2_last", 32'(out_last), 1);
    chk("t2_repeat", 32'(rep_repeat), 0);
    cyc();
    req(3'd4, 3'd1, 30'h22, 32'h0);
    #1;
    chk("t2_addr_b", 32'(out_address), 32'h22);
    chk("t2_size_b", 32'(out_size), 1);
    chk("t2_last_b", 32'(out_last), 1);
    cyc();
    drain(2);
    drain(1);
    chk("t2_no_underflow", 32'(busy), 0);

    // 3: PutFull of 8 bytes, two upstream beats
    req(3'd0, 3'd3, 30'h40, 32'hAAAA0001);
    #1;
    chk("t3_addr0", 32'(out_address), 32'h40);
    chk("t3_data0", out_data, 32'hAAAA0001);
    chk("t3_repeat0", 32'(rep_repeat), 0);
    chk("t3_last0", 32'(out_last), 0);
    cyc();
    req(3'd0, 3'd3, 30'h40, 32'hBBBB0002);
    #1;
    chk("t3_addr1", 32'(out_address), 32'h44);
    chk("t3_data1", out_data, 32'hBBBB0002);
    chk("t3_repeat1", 32'(rep_repeat), 0);
    chk("t3_last1", 32'(out_last), 1);
    cyc();
    drain(2);

    // 4: Get 32 bytes at 0 against the outstanding limit
    for (int i = 0; i < 4; i++) begin
      req(3'd4, 3'd5, 30'h0, 32'h0);
      #1;
      chk("t4_fill", 32'(out_address), 32'(4 * i));
      cyc();
    end
    #1;
    chk("t4_stall_valid", 32'(out_valid), 0);
    chk("t4_stall_ready", 32'(rep_ready), 0);
    cyc();
    chk("t4_stall_hold", 32'(out_valid), 0);
    d_fire = 1'b1;
    cyc();
    d_fire = 1'b0;
    #1;
    chk("t4_resume_valid", 32'(out_valid), 1);
    chk("t4_resume_addr", 32'(out_address), 32'h10);
    cyc();
    #1;
    chk("t4_restall", 32'(out_valid), 0);
    chk("t4_restall_addr", 32'(out_address), 32'h14);
    d_fire = 1'b1;
    cyc();
    // fire and acknowledge together on 0x14
    #1;
    chk("t4_both_valid", 32'(out_valid), 1);
    cyc();
    d_fire = 1'b0;
    #1;
    chk("t4_const_valid", 32'(out_valid), 1);
    chk("t4_const_addr", 32'(out_address), 32'h18);
    cyc();
    #1;
    chk("t4_stall_1c", 32'(out_valid), 0);
    d_fire = 1'b1;
    cyc();
    d_fire = 1'b0;
    #1;
    chk("t4_tail_addr", 32'(out_address), 32'h1C);
    chk("t4_tail_last", 32'(out_last), 1);
    cyc();
    drain(4);
    chk("t4_idle", 32'(busy), 0);

    // 5: backpressure in the middle of a Get burst
    req(3'd4, 3'd4, 30'h200, 32'h0);
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_addr", 32'(out_address), 32'h204);
      chk("t5_hold_repeat", 32'(rep_repeat), 1);
      chk("t5_hold_ready", 32'(rep_ready), 0);
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("t5_resume_addr", 32'(out_address), 32'h200 + 32'(4 * i));
      cyc();
    end
    drain(4);

    // 6: reset in the middle of a burst
    req(3'd4, 3'd4, 30'h300, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_addr", 32'(out_address), 32'h300);
    chk("t6_rst_valid", 32'(out_valid), 1);
    rep_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    req(3'd4, 3'd2, 30'h80, 32'h0);
    #1;
    chk("t6_addr", 32'(out_address), 32'h80);
    chk("t6_last", 32'(out_last), 1);
    chk("t6_valid", 32'(out_valid), 1);
    cyc();
    rep_valid = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 1);
    drain(1);
    chk("t6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
